// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable wait states and a one-cycle response strobe.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbgState
);

  // Handshake: a request is accepted on a rising edge where req_valid and
  // req_ready are both high; rsp_valid is a single-cycle strobe per accept.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, nextState;

  logic [3:0]    waitCnt;
  logic          capWe;
  logic [AW-1:0] capIdx;
  logic [31:0]   capWdata;
  logic [3:0]    capBe;
  logic          capOor;

  logic          inIdle;
  logic          accept;
  logic          enterResp;
  logic          reqOor;
  logic          unusedAddr;

  logic          effWe;
  logic [AW-1:0] effIdx;
  logic [31:0]   effWdata;
  logic [3:0]    effBe;
  logic          effOor;

  logic [31:0]   mem [DEPTH_WORDS];

`ifdef DMEM_RANGE_CHECK_EN
  assign reqOor     = |req_addr[31:AW+2];
  assign unusedAddr = ^req_addr[1:0];
`else
  assign reqOor     = 1'b0;
  assign unusedAddr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign inIdle    = (state == IDLE);
  assign accept    = inIdle && reset && req_valid;
  assign enterResp = (nextState == RESP);

  // With zero latency RESP is entered on the accept edge itself, so the live
  // request must be used there instead of the not-yet-captured copy.
  assign effWe    = inIdle ? req_we            : capWe;
  assign effIdx   = inIdle ? req_addr[AW+1:2]  : capIdx;
  assign effWdata = inIdle ? req_wdata         : capWdata;
  assign effBe    = inIdle ? req_be            : capBe;
  assign effOor   = inIdle ? reqOor            : capOor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = (LATENCY > 0) ? WAIT : RESP;
      WAIT: if (waitCnt == 4'd1) nextState = RESP;
      RESP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = inIdle && reset;
    busy      = !inIdle;
    rsp_valid = (state == RESP);
    dbgState  = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt   <= 4'd0;
      capWe     <= 1'b0;
      capIdx    <= '0;
      capWdata  <= 32'd0;
      capBe     <= 4'd0;
      capOor    <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        waitCnt  <= 4'(LATENCY);
        capWe    <= req_we;
        capIdx   <= req_addr[AW+1:2];
        capWdata <= req_wdata;
        capBe    <= req_be;
        capOor   <= reqOor;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (enterResp) begin
        rsp_rdata <= (effWe || effOor) ? 32'd0 : mem[effIdx];
        rsp_err   <= effOor;
      end
    end
  end

  // Array is not reset; the reset term keeps an abandoned transaction from writing.
  always_ff @(posedge clk) begin
    if (reset && enterResp && effWe && !effOor) begin
      for (int i = 0; i < 4; i++) begin
        if (effBe[i]) mem[effIdx][8*i +: 8] <= effWdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (LATENCY 2 and 0) checked against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic        clk = 1'b0;
  logic        rstN      [2];
  logic        reqValid  [2];
  logic        reqWe     [2];
  logic [31:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic [3:0]  reqBe     [2];
  logic        reqReady  [2];
  logic        rspValid  [2];
  logic [31:0] rspRdata  [2];
  logic        rspErr    [2];
  logic        busy      [2];
  logic [1:0]  dbgState  [2];

  logic [31:0] model [2][DEPTH];
  logic [31:0] expQ[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    ((g == 0) ? LAT0 : LAT1)
    ) u (
      .clk      (clk),
      .reset    (rstN[g]),
      .req_valid(reqValid[g]),
      .req_we   (reqWe[g]),
      .req_addr (reqAddr[g]),
      .req_wdata(reqWdata[g]),
      .req_be   (reqBe[g]),
      .req_ready(reqReady[g]),
      .rsp_valid(rspValid[g]),
      .rsp_rdata(rspRdata[g]),
      .rsp_err  (rspErr[g]),
      .busy     (busy[g]),
      .dbgState (dbgState[g])
    );
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int latOf(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int idxOf(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic bit oorOf(input logic [31:0] addr);
`ifdef DMEM_RANGE_CHECK_EN
    return addr >= 32'(DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction: drive, time the response, compare against the model.
  task automatic doTxn(input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    int idx;
    bit oor;
    bit got;
    int n;
    logic [31:0] expData;
    idx = idxOf(addr);
    oor = oorOf(addr);
    if (we) begin
      expData = 32'd0;
      if (!oor) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[d][idx][8*i +: 8] = wdata[8*i +: 8];
      end
    end else begin
      expData = oor ? 32'd0 : model[d][idx];
    end
    expQ.push_back(expData);

    @(negedge clk);
    checkVal("ready_idle", 32'(reqReady[d]), 32'd1);
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqBe[d]    = be;
    @(posedge clk); #1;
    checkVal("ready_drop", 32'(reqReady[d]), 32'd0);
    checkVal("busy_accept", 32'(busy[d]), 32'd1);
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      if (rspValid[d]) begin
        got = 1'b1;
      end else begin
        checkVal("busy_wait", 32'(busy[d]), 32'd1);
        // Junk on the request bus while not idle must be ignored.
        @(negedge clk);
        reqValid[d] = 1'($urandom_range(0, 1));
        reqWe[d]    = 1'($urandom_range(0, 1));
        reqAddr[d]  = $urandom;
        reqWdata[d] = $urandom;
        reqBe[d]    = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        n++;
      end
    end
    expData = expQ.pop_front();
    checkVal("rsp_seen", 32'(got), 32'd1);
    if (got) begin
      checkVal("latency", 32'(n), 32'(latOf(d)));
      checkVal("rdata", rspRdata[d], expData);
      checkVal("err", 32'(rspErr[d]), 32'(oor));
      checkVal("busy_resp", 32'(busy[d]), 32'd1);
    end
    @(negedge clk);
    reqValid[d] = 1'b0;
    @(posedge clk); #1;
    checkVal("rsp_single", 32'(rspValid[d]), 32'd0);
    checkVal("busy_idle", 32'(busy[d]), 32'd0);
    checkVal("ready_back", 32'(reqReady[d]), 32'd1);
    checkVal("rdata_hold", rspRdata[d], expData);
  endtask

  task automatic randomTxn(input int d);
    logic [31:0] addr;
    addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 4095)) << 10);
    doTxn(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // Reset one cycle after accept: no response, no write, registers cleared.
  task automatic resetMidWait();
    bit sawRsp;
    logic [31:0] addr;
    addr = 32'h40;
    @(negedge clk);
    reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = addr;
    reqWdata[0] = 32'h55; reqBe[0] = 4'hF;
    @(posedge clk); #1;
    checkVal("rm_accept", 32'(busy[0]), 32'd1);
    @(negedge clk);
    reqValid[0] = 1'b0;
    @(posedge clk); #2;
    sawRsp = rspValid[0];
    rstN[0] = 1'b0;
    #1;
    checkVal("rm_busy", 32'(busy[0]), 32'd0);
    checkVal("rm_ready", 32'(reqReady[0]), 32'd0);
    checkVal("rm_rdata", rspRdata[0], 32'd0);
    @(negedge clk);
    rstN[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      sawRsp = sawRsp | rspValid[0];
    end
    checkVal("rm_no_rsp", 32'(sawRsp), 32'd0);
    doTxn(0, 1'b0, addr, 32'd0, 4'h0);
  endtask

  // LATENCY=0 with req_valid held high: accept on every other edge.
  task automatic backToBack();
    logic [31:0] a [2];
    a[0] = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
    a[1] = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
    @(negedge clk);
    reqValid[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = a[0];
    reqWdata[1] = $urandom; reqBe[1] = 4'($urandom_range(0, 15));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        checkVal("b2b_busy1", 32'(busy[1]), 32'd1);
        checkVal("b2b_rsp1", 32'(rspValid[1]), 32'd1);
        checkVal("b2b_rdata", rspRdata[1], model[1][idxOf(a[(k / 2) % 2])]);
        @(negedge clk);
        reqAddr[1] = a[(k / 2 + 1) % 2];
      end else begin
        checkVal("b2b_busy0", 32'(busy[1]), 32'd0);
        checkVal("b2b_rsp0", 32'(rspValid[1]), 32'd0);
        checkVal("b2b_ready", 32'(reqReady[1]), 32'd1);
      end
    end
    @(negedge clk);
    reqValid[1] = 1'b0;
    @(posedge clk); #1;
    checkVal("b2b_stop", 32'(busy[1]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstN[d] = 1'b0; reqValid[d] = 1'b0; reqWe[d] = 1'b0;
      reqAddr[d] = 32'd0; reqWdata[d] = 32'd0; reqBe[d] = 4'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkVal("rst_ready", 32'(reqReady[d]), 32'd0);
      checkVal("rst_rsp", 32'(rspValid[d]), 32'd0);
      checkVal("rst_busy", 32'(busy[d]), 32'd0);
      checkVal("rst_rdata", rspRdata[d], 32'd0);
      checkVal("rst_err", 32'(rspErr[d]), 32'd0);
    end
    @(negedge clk);
    rstN[0] = 1'b1; rstN[1] = 1'b1;
    #1;
    checkVal("rel_ready0", 32'(reqReady[0]), 32'd1);
    checkVal("rel_ready1", 32'(reqReady[1]), 32'd1);

    doTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    doTxn(0, 1'b0, 32'h10, 32'd0, 4'h0);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        doTxn(d, 1'b1, 32'(i * 4), $urandom, 4'hF);

    doTxn(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    doTxn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    doTxn(0, 1'b0, 32'h20, 32'd0, 4'hF);
    checkVal("be_model", model[0][8], 32'h11BB33DD);

    doTxn(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
    doTxn(0, 1'b0, 32'h0, 32'd0, 4'hF);

    doTxn(0, 1'b1, 32'h8, 32'h12345678, 4'hF);
    doTxn(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
    doTxn(0, 1'b0, 32'h8, 32'd0, 4'hF);

    resetMidWait();
    backToBack();

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 150; i++)
        randomTxn(d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
